// File: rtl/sketch_flush_ctrl.sv
// sketch_flush_ctrl
//   Epoch readout/clear controller for the sketch counter and ID RAMs. A flush request stalls
//   the insert pipeline, waits for it to drain, then sweeps every RAM address: read, stream
//   {addr, count, id} to the host, write zero. The port is handed back when the sweep ends.
//
// Ports
//   sys_clk, rst_n     clock, asynchronous active-low reset
//   flush_req          start pulse, honoured only when idle
//   ins_active         insert pipeline still has an element in flight
//   ins_stall          blocks new inserts upstream (DRAIN..DONE)
//   flush_busy         controller owns the RAM port (READ..CLEAR)
//   flush_done         one-cycle pulse when the sweep completes
//   flush_entries      entries streamed in the last sweep
//   ram_en/we/addr/din shared counter/ID RAM port; din is always zero
//   cnt_rdata/id_rdata RAM read data, one cycle after a read
//   out_valid/ready    host stream handshake
//   out_addr/count/id  stream payload, held while out_valid && !out_ready
module sketch_flush_ctrl #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter bit          SKIP_ZERO = 1'b1
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              flush_req,
   input  logic              ins_active,
   output logic              ins_stall,
   output logic              flush_busy,
   output logic              flush_done,
   output logic [ADDR_W:0]   flush_entries,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] cnt_rdata,
   input  logic [DATA_W-1:0] id_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_count,
   output logic [DATA_W-1:0] out_id
);

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StRead,
      StWait,
      StEmit,
      StClear,
      StDone
   } state_e;

   localparam logic [ADDR_W-1:0] PtrLast = {ADDR_W{1'b1}};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   entries_q, entries_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] id_q, id_d;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         entries_q <= '0;
         addr_q    <= '0;
         count_q   <= '0;
         id_q      <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         entries_q <= entries_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         id_q      <= id_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      entries_d  = entries_q;
      addr_d     = addr_q;
      count_d    = count_q;
      id_d       = id_q;
      ins_stall  = 1'b0;
      flush_busy = 1'b0;
      flush_done = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      out_valid  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (flush_req) begin
               state_d   = StDrain;
               ptr_d     = '0;
               entries_d = '0;
            end
         end
         StDrain: begin
            ins_stall = 1'b1;
            if (!ins_active) state_d = StRead;
         end
         StRead: begin
            ins_stall  = 1'b1;
            flush_busy = 1'b1;
            ram_en     = 1'b1;
            state_d    = StWait;
         end
         StWait: begin
            // Read data is valid now; latch the whole beat so it stays stable during back-pressure.
            ins_stall  = 1'b1;
            flush_busy = 1'b1;
            addr_d     = ptr_q;
            count_d    = cnt_rdata;
            id_d       = id_rdata;
            if (SKIP_ZERO && (cnt_rdata == '0)) state_d = StClear;
            else                                state_d = StEmit;
         end
         StEmit: begin
            ins_stall  = 1'b1;
            flush_busy = 1'b1;
            out_valid  = 1'b1;
            if (out_ready) begin
               entries_d = entries_q + 1'b1;
               state_d   = StClear;
            end
         end
         StClear: begin
            ins_stall  = 1'b1;
            flush_busy = 1'b1;
            ram_en     = 1'b1;
            ram_we     = 1'b1;
            if (ptr_q == PtrLast) begin
               state_d = StDone;
            end else begin
               ptr_d   = ptr_q + 1'b1;
               state_d = StRead;
            end
         end
         StDone: begin
            ins_stall  = 1'b1;
            flush_done = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign ram_addr      = ptr_q;
   assign ram_din       = '0;
   assign flush_entries = entries_q;
   assign out_addr      = addr_q;
   assign out_count     = count_q;
   assign out_id        = id_q;

endmodule

// File: tb/tb_sketch_flush_ctrl.sv
// Bench for sketch_flush_ctrl with ADDR_W=3 (8 entries), SKIP_ZERO=1, behavioural RAM model.
module tb_sketch_flush_ctrl;

   localparam int unsigned AW    = 3;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 8;

   logic          sys_clk = 1'b0;
   logic          rst_n;
   logic          flush_req;
   logic          ins_active;
   logic          ins_stall;
   logic          flush_busy;
   logic          flush_done;
   logic [AW:0]   flush_entries;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] cnt_rdata;
   logic [DW-1:0] id_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_count;
   logic [DW-1:0] out_id;

   always #5 sys_clk = ~sys_clk;

   sketch_flush_ctrl #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .SKIP_ZERO(1'b1)
   ) dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .flush_req    (flush_req),
      .ins_active   (ins_active),
      .ins_stall    (ins_stall),
      .flush_busy   (flush_busy),
      .flush_done   (flush_done),
      .flush_entries(flush_entries),
      .ram_en       (ram_en),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din),
      .cnt_rdata    (cnt_rdata),
      .id_rdata     (id_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_addr     (out_addr),
      .out_count    (out_count),
      .out_id       (out_id)
   );

   // Counter/ID RAM model with a bench-side preload port.
   logic [DW-1:0] cnt_mem [DEPTH];
   logic [DW-1:0] id_mem  [DEPTH];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_cnt;
   logic [DW-1:0] pl_id;

   always @(posedge sys_clk) begin
      if (pl_en) begin
         cnt_mem[pl_addr] <= pl_cnt;
         id_mem[pl_addr]  <= pl_id;
      end else if (ram_en) begin
         if (ram_we) begin
            cnt_mem[ram_addr] <= ram_din;
            id_mem[ram_addr]  <= ram_din;
         end else begin
            cnt_rdata <= cnt_mem[ram_addr];
            id_rdata  <= id_mem[ram_addr];
         end
      end
   end

   int unsigned   n_cmp = 0;
   int unsigned   n_bad = 0;
   logic [DW-1:0] sh_cnt [DEPTH];
   logic [DW-1:0] sh_id  [DEPTH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat_cnt(input int unsigned p, input int unsigned a);
      case (p)
         0:       return DW'(a + 1);
         1:       return '0;
         default: return (a % 2 == 0) ? DW'(a + 1) : '0;
      endcase
   endfunction

   task automatic preload(input int unsigned p);
      for (int a = 0; a < DEPTH; a++) begin
         pl_en   = 1'b1;
         pl_addr = AW'(a);
         pl_cnt  = pat_cnt(p, a);
         pl_id   = DW'(32'h100 + a);
         sh_cnt[a] = pl_cnt;
         sh_id[a]  = pl_id;
         @(posedge sys_clk);
         #1;
      end
      pl_en = 1'b0;
   endtask

   task automatic check_ram_clear(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         check({tag, " cnt_mem zero"}, 64'(cnt_mem[a]), 64'd0);
         check({tag, " id_mem zero"}, 64'(id_mem[a]), 64'd0);
         sh_cnt[a] = '0;
         sh_id[a]  = '0;
      end
   endtask

   // Runs one sweep from a flush_req pulse; beats are checked against the shadow RAM in order.
   // Observation c is taken 1 time unit after the c-th rising edge following the request.
   task automatic run_flush(input bit toggle, input int unsigned hold, input bit req_again,
                            output int unsigned done_obs, output int unsigned n_done);
      int unsigned   exp_q[$];
      int unsigned   a;
      logic          prev_hold;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_cnt;
      logic [DW-1:0] p_id;
      for (int i = 0; i < DEPTH; i++) if (sh_cnt[i] != '0) exp_q.push_back(i);
      done_obs   = 0;
      n_done     = 0;
      prev_hold  = 1'b0;
      p_addr     = '0;
      p_cnt      = '0;
      p_id       = '0;
      ins_active = (hold != 0);
      flush_req  = 1'b1;
      for (int unsigned c = 1; c <= 400; c++) begin
         @(posedge sys_clk);
         #1;
         flush_req = 1'b0;
         if (c == hold) ins_active = 1'b0;
         if (req_again && c == 15) flush_req = 1'b1;
         out_ready = toggle ? c[0] : 1'b1;
         if (c <= hold) begin
            check("drain ins_stall", 64'(ins_stall), 64'd1);
            check("drain ram_en", 64'(ram_en), 64'd0);
         end
         if (hold != 0 && c == hold + 1) begin
            check("first read en/we/addr", {62'(ram_addr), ram_en, ram_we}, {62'd0, 1'b1, 1'b0});
         end
         if (prev_hold) begin
            check("held out_valid", 64'(out_valid), 64'd1);
            check("held out_addr", 64'(out_addr), 64'(p_addr));
            check("held out_count/id", {out_count, out_id}, {p_cnt, p_id});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected beat addr", 64'(out_addr), 64'hffff);
            end else begin
               a = exp_q.pop_front();
               check("beat addr", 64'(out_addr), 64'(a));
               check("beat count/id", {out_count, out_id}, {sh_cnt[a], sh_id[a]});
            end
         end
         prev_hold = out_valid && !out_ready;
         p_addr    = out_addr;
         p_cnt     = out_count;
         p_id      = out_id;
         if (flush_done) begin
            n_done++;
            if (done_obs == 0) done_obs = c;
            if (req_again) flush_req = 1'b1;
         end
         if (done_obs != 0 && c >= done_obs + 3) break;
      end
      check("beats missing", 64'(exp_q.size()), 64'd0);
      check("idle after sweep", {62'd0, ins_stall, flush_busy}, 64'd0);
      flush_req  = 1'b0;
      ins_active = 1'b0;
      out_ready  = 1'b1;
   endtask

   typedef struct {
      int unsigned pattern;
      bit          toggle;
      int unsigned hold;
      bit          req_again;
      int unsigned exp_entries;
      int unsigned exp_done;  // observation index of flush_done; 0 = not checked
   } scen_t;

   scen_t scen [5];

   initial begin
      int unsigned done_obs;
      int unsigned n_done;
      int unsigned n_done6;

      // Done index = first READ (obs 2, or hold+1) + 4 per streamed + 3 per skipped entry.
      scen[0] = '{pattern: 0, toggle: 1'b0, hold: 0,  req_again: 1'b0, exp_entries: 8, exp_done: 34};
      scen[1] = '{pattern: 1, toggle: 1'b0, hold: 0,  req_again: 1'b0, exp_entries: 0, exp_done: 26};
      scen[2] = '{pattern: 0, toggle: 1'b1, hold: 0,  req_again: 1'b0, exp_entries: 8, exp_done: 0};
      scen[3] = '{pattern: 0, toggle: 1'b0, hold: 10, req_again: 1'b0, exp_entries: 8, exp_done: 43};
      scen[4] = '{pattern: 2, toggle: 1'b0, hold: 0,  req_again: 1'b1, exp_entries: 4, exp_done: 30};

      rst_n      = 1'b1;
      flush_req  = 1'b0;
      ins_active = 1'b0;
      out_ready  = 1'b1;
      pl_en      = 1'b0;
      pl_addr    = '0;
      pl_cnt     = '0;
      pl_id      = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset ctrl", {ins_stall, flush_busy, flush_done, flush_entries, ram_en, ram_we,
                           ram_addr, out_valid, out_addr}, 64'd0);
      check("reset data", {out_count, out_id}, 64'd0);
      check("reset ram_din", 64'(ram_din), 64'd0);
      repeat (2) @(posedge sys_clk);
      #1 rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      check("post-reset idle", {ins_stall, flush_busy, ram_en, out_valid}, 64'd0);

      for (int s = 0; s < 5; s++) begin
         preload(scen[s].pattern);
         run_flush(scen[s].toggle, scen[s].hold, scen[s].req_again, done_obs, n_done);
         check($sformatf("scen%0d flush_done count", s), 64'(n_done), 64'd1);
         check($sformatf("scen%0d flush_entries", s), 64'(flush_entries), 64'(scen[s].exp_entries));
         if (scen[s].exp_done != 0)
            check($sformatf("scen%0d done cycle", s), 64'(done_obs), 64'(scen[s].exp_done));
         check_ram_clear($sformatf("scen%0d", s));
      end

      // Reset during the EMIT of address 4 aborts the sweep with entries 0..3 already cleared.
      preload(0);
      n_done6   = 0;
      flush_req = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge sys_clk);
         #1;
         flush_req = 1'b0;
         if (flush_done) n_done6++;
         if (out_valid && out_addr == AW'(4)) break;
      end
      check("reached emit of addr 4", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("async reset ctrl", {ins_stall, flush_busy, flush_done, flush_entries, ram_en, ram_we,
                                 ram_addr, out_valid, out_addr}, 64'd0);
      check("async reset data", {out_count, out_id}, 64'd0);
      repeat (2) begin
         @(posedge sys_clk);
         #1;
         if (flush_done) n_done6++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge sys_clk);
         #1;
         if (flush_done) n_done6++;
      end
      check("no done on abort", 64'(n_done6), 64'd0);
      check("addr 3 cleared", {cnt_mem[3], id_mem[3]}, 64'd0);
      check("addr 4 intact", {cnt_mem[4], id_mem[4]}, {32'd5, 32'h104});
      for (int a = 0; a < 4; a++) begin
         sh_cnt[a] = '0;
         sh_id[a]  = '0;
      end
      run_flush(1'b0, 0, 1'b0, done_obs, n_done);
      check("resume flush_done count", 64'(n_done), 64'd1);
      check("resume flush_entries", 64'(flush_entries), 64'd4);
      check("resume done cycle", 64'(done_obs), 64'd30);
      check_ram_clear("resume");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
